register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter XLEN, default 64: data, PC and register width in bits.
REQ-002 Parameter NUM_REGS, default 32: number of integer registers x0..x31, addressed by 5 bits.
REQ-003 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst.
REQ-004 clk  input  1  clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 rs1_addr  input  5  read port 1 register index.
REQ-007 rs2_addr  input  5  read port 2 register index.
REQ-008 rs1_data  output  XLEN  contents of register rs1_addr.
REQ-009 rs2_data  output  XLEN  contents of register rs2_addr.
REQ-010 rd_addr  input  5  write port register index.
REQ-011 rd_data  input  XLEN  write port data.
REQ-012 rfile_we  input  1  register write enable.
REQ-013 pc  output  XLEN  current program counter.
REQ-014 pc_write_data  input  XLEN  PC load value.
REQ-015 pc_we  input  1  PC load enable.
REQ-016 pc_increment  input  1  PC advance enable.
REQ-017 ebreak_set  input  1  sets the internal halt flag.
REQ-018 ebreak_clear  input  1  clears the internal halt flag.

Function
REQ-019 Reads SHALL be combinational: rs1_data/rs2_data follow rs1_addr/rs2_addr and stored contents with no clock dependency.
REQ-020 Reading x0 SHALL always return 0 on both ports.
REQ-021 On a rising clk edge with rfile_we=1 and rd_addr!=0, register rd_addr SHALL take rd_data.
REQ-022 Writes with rd_addr=0 SHALL be discarded.
REQ-023 A same-cycle read of the register being written SHALL return the old value until the edge; no write-to-read bypass.
REQ-024 Both read ports SHALL be independent; equal addresses on both ports return the same value.
REQ-025 On a rising edge with pc_we=1, pc SHALL load pc_write_data.
REQ-026 On a rising edge with pc_we=0, pc_increment=1 and halt flag clear, pc SHALL become pc+4, modulo 2^XLEN (wraps to 0 past all-ones).
REQ-027 pc_we SHALL have priority over pc_increment in the same cycle.
REQ-028 With neither pc_we nor an enabled increment, pc SHALL hold.
REQ-029 The halt flag SHALL set on a rising edge with ebreak_set=1 and clear on a rising edge with ebreak_clear=1 and ebreak_set=0; ebreak_set SHALL win on simultaneous assertion.
REQ-030 While the halt flag is set, pc_increment SHALL be ignored; pc_we and register writes SHALL still take effect.
REQ-031 Register writes and PC updates in the same cycle SHALL both take effect independently.

Reset
REQ-032 On a rising edge with rst=1, all registers SHALL be 0, pc SHALL be 0 and the halt flag SHALL be cleared, overriding every other input that cycle.
REQ-033 rst asserted mid-operation SHALL discard any write or PC update requested in that cycle.

Verification
REQ-034 Hold rst for 2+ cycles, then sweep rs1_addr/rs2_addr over 0..31 -> all reads 0 and pc=0.
REQ-035 Pulse pc_increment for one cycle -> pc=0x4; then pc_we=1 with pc_write_data=0xDEADBEEF -> pc=0x00000000DEADBEEF; pc_we and pc_increment together -> pc=pc_write_data.
REQ-036 Write rd_addr=0, rd_data=0xFFFF -> rs1_data=rs2_data=0 at address 0.
REQ-037 Write x_i = 0x0F00+i for i=1..31, then read every index on each port -> 0x0F00+i, and 0 at index 0.
REQ-038 Assert ebreak_set, then pc_increment -> pc unchanged; assert ebreak_clear, then pc_increment -> pc advances by 4.
REQ-039 Set pc to 0xFFFFFFFFFFFFFFFC and increment -> pc=0; assert rst together with rfile_we -> target register reads 0.

Source files
------------

// File: rtl/register_file_if.sv
`default_nettype none
// ============================================================================
// Module   : register_file_if
// Purpose  : Bus bundle for the integer register file: read/write ports,
//            PC control and halt-flag control.
// Revision : 1.0 - initial release
// ============================================================================
interface register_file_if #(
    parameter int XLEN = 64
);
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            rfile_we;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_write_data;
    logic            pc_we;
    logic            pc_increment;
    logic            ebreak_set;
    logic            ebreak_clear;

    modport master (
        output rs1_addr, rs2_addr, rd_addr, rd_data, rfile_we,
               pc_write_data, pc_we, pc_increment, ebreak_set, ebreak_clear,
        input  rs1_data, rs2_data, pc
    );

    modport slave (
        input  rs1_addr, rs2_addr, rd_addr, rd_data, rfile_we,
               pc_write_data, pc_we, pc_increment, ebreak_set, ebreak_clear,
        output rs1_data, rs2_data, pc
    );
endinterface
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module   : register_file
// Purpose  : Integer register file (x0 hardwired to zero, two async read
//            ports, one write port) with program counter and halt flag.
// Revision : 1.0 - initial release
// ============================================================================
module register_file #(
    parameter int XLEN     = 64,
    parameter int NUM_REGS = 32
) (
    input  logic           clk,
    input  logic           rst,
    register_file_if.slave rf
);
    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

    logic [XLEN-1:0] r_regs [NUM_REGS];
    logic [XLEN-1:0] r_pc;
    logic            r_halt;
    logic [XLEN-1:0] w_rs1;
    logic [XLEN-1:0] w_rs2;
    logic            w_wr_en;

    // x0 and indices beyond NUM_REGS read as zero; no bypass from the write port
    always_comb begin
        w_rs1 = '0;
        if (rf.rs1_addr != 5'd0 && 32'(rf.rs1_addr) < NUM_REGS) begin
            w_rs1 = r_regs[rf.rs1_addr];
        end
    end

    always_comb begin
        w_rs2 = '0;
        if (rf.rs2_addr != 5'd0 && 32'(rf.rs2_addr) < NUM_REGS) begin
            w_rs2 = r_regs[rf.rs2_addr];
        end
    end

    assign w_wr_en = rf.rfile_we && (rf.rd_addr != 5'd0) && (32'(rf.rd_addr) < NUM_REGS);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[rf.rd_addr] <= rf.rd_data;
        end
    end

    // Increment gating uses the flag value before this edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= '0;
            r_halt <= 1'b0;
        end else begin
            if (rf.pc_we) begin
                r_pc <= rf.pc_write_data;
            end else if (rf.pc_increment && !r_halt) begin
                r_pc <= r_pc + c_pc_step;
            end

            if (rf.ebreak_set) begin
                r_halt <= 1'b1;
            end else if (rf.ebreak_clear) begin
                r_halt <= 1'b0;
            end
        end
    end

    assign rf.rs1_data = w_rs1;
    assign rf.rs2_data = w_rs2;
    assign rf.pc       = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file
// Purpose  : Directed, table-driven self-checking bench for register_file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_file;
    localparam int XLEN = 64;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    register_file_if #(.XLEN(XLEN)) rf_bus ();

    register_file #(.XLEN(XLEN), .NUM_REGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic            we;
        logic [4:0]      rd;
        logic [XLEN-1:0] wd;
        logic            pwe;
        logic [XLEN-1:0] pwd;
        logic            inc;
        logic            es;
        logic            ec;
        logic [4:0]      a1;
        logic [4:0]      a2;
        logic [XLEN-1:0] e1;
        logic [XLEN-1:0] e2;
        logic [XLEN-1:0] epc;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(
        input logic rst_i, input logic we, input logic [4:0] rd, input logic [XLEN-1:0] wd,
        input logic pwe, input logic [XLEN-1:0] pwd, input logic inc, input logic es,
        input logic ec, input logic [4:0] a1, input logic [4:0] a2,
        input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2, input logic [XLEN-1:0] epc);
        vec_t v;
        v.rst = rst_i; v.we = we; v.rd = rd; v.wd = wd; v.pwe = pwe; v.pwd = pwd;
        v.inc = inc; v.es = es; v.ec = ec; v.a1 = a1; v.a2 = a2;
        v.e1 = e1; v.e2 = e2; v.epc = epc;
        return v;
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        rst                  = 1'b0;
        rf_bus.rfile_we      = 1'b0;
        rf_bus.rd_addr       = 5'd0;
        rf_bus.rd_data       = '0;
        rf_bus.pc_we         = 1'b0;
        rf_bus.pc_write_data = '0;
        rf_bus.pc_increment  = 1'b0;
        rf_bus.ebreak_set    = 1'b0;
        rf_bus.ebreak_clear  = 1'b0;
        rf_bus.rs1_addr      = 5'd0;
        rf_bus.rs2_addr      = 5'd0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive_idle();

        //          rst   we    rd     wd         pwe   pwd                    inc   es    ec    a1     a2     e1         e2         epc
        vecs[0]  = mk(1'b0, 1'b0, 5'd0, 64'h0,     1'b0, 64'h0,                 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 64'h0,     64'h0,     64'h0);
        vecs[1]  = mk(1'b0, 1'b0, 5'd0, 64'h0,     1'b0, 64'h0,                 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 64'h0,     64'h0,     64'h4);
        vecs[2]  = mk(1'b0, 1'b0, 5'd0, 64'h0,     1'b1, 64'hDEADBEEF,          1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 64'h0,     64'h0,     64'h00000000DEADBEEF);
        vecs[3]  = mk(1'b0, 1'b0, 5'd0, 64'h0,     1'b1, 64'h100,               1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 64'h0,     64'h0,     64'h100);
        vecs[4]  = mk(1'b0, 1'b0, 5'd0, 64'h0,     1'b0, 64'h0,                 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 64'h0,     64'h0,     64'h100);
        vecs[5]  = mk(1'b0, 1'b1, 5'd0, 64'hFFFF,  1'b0, 64'h0,                 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 64'h0,     64'h0,     64'h100);
        vecs[6]  = mk(1'b0, 1'b1, 5'd5, 64'h55,    1'b0, 64'h0,                 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 64'h55,    64'h55,    64'h100);
        vecs[7]  = mk(1'b0, 1'b1, 5'd6, 64'h66,    1'b0, 64'h0,                 1'b1, 1'b0, 1'b0, 5'd5, 5'd6, 64'h55,    64'h66,    64'h104);
        vecs[8]  = mk(1'b0, 1'b0, 5'd0, 64'h0,     1'b0, 64'h0,                 1'b0, 1'b1, 1'b0, 5'd6, 5'd5, 64'h66,    64'h55,    64'h104);
        vecs[9]  = mk(1'b0, 1'b0, 5'd0, 64'h0,     1'b0, 64'h0,                 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 64'h0,     64'h0,     64'h104);
        vecs[10] = mk(1'b0, 1'b1, 5'd7, 64'h77,    1'b0, 64'h0,                 1'b1, 1'b0, 1'b0, 5'd7, 5'd0, 64'h77,    64'h0,     64'h104);
        vecs[11] = mk(1'b0, 1'b0, 5'd0, 64'h0,     1'b1, 64'h200,               1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 64'h0,     64'h0,     64'h200);
        vecs[12] = mk(1'b0, 1'b0, 5'd0, 64'h0,     1'b0, 64'h0,                 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 64'h0,     64'h0,     64'h200);
        vecs[13] = mk(1'b0, 1'b0, 5'd0, 64'h0,     1'b0, 64'h0,                 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 64'h0,     64'h0,     64'h200);
        vecs[14] = mk(1'b0, 1'b0, 5'd0, 64'h0,     1'b0, 64'h0,                 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 64'h0,     64'h0,     64'h200);
        vecs[15] = mk(1'b0, 1'b0, 5'd0, 64'h0,     1'b0, 64'h0,                 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 64'h0,     64'h0,     64'h204);
        vecs[16] = mk(1'b0, 1'b0, 5'd0, 64'h0,     1'b1, 64'hFFFFFFFFFFFFFFFC,  1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 64'h0,     64'h0,     64'hFFFFFFFFFFFFFFFC);
        vecs[17] = mk(1'b0, 1'b0, 5'd0, 64'h0,     1'b0, 64'h0,                 1'b1, 1'b1, 1'b0, 5'd5, 5'd6, 64'h55,    64'h66,    64'h0);
        vecs[18] = mk(1'b1, 1'b1, 5'd5, 64'hAAAA,  1'b1, 64'h300,               1'b1, 1'b0, 1'b0, 5'd5, 5'd6, 64'h0,     64'h0,     64'h0);
        vecs[19] = mk(1'b0, 1'b0, 5'd0, 64'h0,     1'b0, 64'h0,                 1'b1, 1'b0, 1'b0, 5'd7, 5'd5, 64'h0,     64'h0,     64'h4);

        // Reset for three cycles, then sweep both read ports
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rf_bus.rs1_addr = 5'(i);
            rf_bus.rs2_addr = 5'(31 - i);
            #1;
            check($sformatf("reset_rs1[%0d]", i), rf_bus.rs1_data, 64'h0);
            check($sformatf("reset_rs2[%0d]", 31 - i), rf_bus.rs2_data, 64'h0);
        end
        check("reset_pc", rf_bus.pc, 64'h0);

        // Table: drive at negedge, sample 1 time unit after the rising edge
        for (int v = 0; v < 20; v++) begin
            @(negedge clk);
            rst                  = vecs[v].rst;
            rf_bus.rfile_we      = vecs[v].we;
            rf_bus.rd_addr       = vecs[v].rd;
            rf_bus.rd_data       = vecs[v].wd;
            rf_bus.pc_we         = vecs[v].pwe;
            rf_bus.pc_write_data = vecs[v].pwd;
            rf_bus.pc_increment  = vecs[v].inc;
            rf_bus.ebreak_set    = vecs[v].es;
            rf_bus.ebreak_clear  = vecs[v].ec;
            rf_bus.rs1_addr      = vecs[v].a1;
            rf_bus.rs2_addr      = vecs[v].a2;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_rs1", v), rf_bus.rs1_data, vecs[v].e1);
            check($sformatf("vec%0d_rs2", v), rf_bus.rs2_data, vecs[v].e2);
            check($sformatf("vec%0d_pc", v), rf_bus.pc, vecs[v].epc);
        end

        // Fill x1..x31, then read every index on both ports
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            drive_idle();
            rf_bus.rfile_we = 1'b1;
            rf_bus.rd_addr  = 5'(i);
            rf_bus.rd_data  = 64'(32'h0F00 + i);
        end
        @(negedge clk);
        drive_idle();
        for (int i = 0; i < 32; i++) begin
            rf_bus.rs1_addr = 5'(i);
            rf_bus.rs2_addr = 5'((i + 7) % 32);
            #1;
            check($sformatf("fill_rs1[%0d]", i), rf_bus.rs1_data,
                  (i == 0) ? 64'h0 : 64'(32'h0F00 + i));
            check($sformatf("fill_rs2[%0d]", (i + 7) % 32), rf_bus.rs2_data,
                  (((i + 7) % 32) == 0) ? 64'h0 : 64'(32'h0F00 + ((i + 7) % 32)));
        end

        // Same-cycle read of the register being written returns the old value
        @(negedge clk);
        drive_idle();
        rf_bus.rfile_we = 1'b1;
        rf_bus.rd_addr  = 5'd3;
        rf_bus.rd_data  = 64'h1234;
        rf_bus.rs1_addr = 5'd3;
        rf_bus.rs2_addr = 5'd3;
        #1;
        check("nobypass_before", rf_bus.rs1_data, 64'h0F03);
        @(posedge clk);
        #1;
        check("nobypass_after_rs1", rf_bus.rs1_data, 64'h1234);
        check("nobypass_after_rs2", rf_bus.rs2_data, 64'h1234);

        @(negedge clk);
        drive_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
